// File: rtl/chunk_head_arb.sv
// Round-robin arbiter that forwards one requester's chunk-head request downstream
// and routes the returned beat stream back to the granted requester.
module chunk_head_arb #(
    parameter int NREQ    = 2,
    parameter int WBW     = 16,
    parameter int VDIM    = 2,
    parameter int ICFG_BW = 4,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [NREQ-1:0]                       i_req_rdy,
    output logic [NREQ-1:0]                       i_req_ack,
    input  logic [NREQ-1:0][VDIM-1:0][WBW-1:0]    i_req_bofs,
    input  logic [NREQ-1:0][VDIM-1:0][WBW-1:0]    i_req_aofs,
    input  logic [NREQ-1:0][ICFG_BW-1:0]          i_req_beg,
    input  logic [NREQ-1:0][ICFG_BW-1:0]          i_req_end,
    output logic                                  o_abofs_rdy,
    input  logic                                  o_abofs_ack,
    output logic [VDIM-1:0][WBW-1:0]              o_bofs,
    output logic [VDIM-1:0][WBW-1:0]              o_aofs,
    output logic [ICFG_BW-1:0]                    o_beg,
    output logic [ICFG_BW-1:0]                    o_end,
    input  logic                                  i_mofs_rdy,
    output logic                                  i_mofs_ack,
    input  logic [VDIM-1:0][WBW-1:0]              i_mofs,
    output logic [NREQ-1:0]                       o_mofs_rdy,
    input  logic [NREQ-1:0]                       o_mofs_ack,
    output logic [VDIM-1:0][WBW-1:0]              o_mofs,
    output logic [GW-1:0]                         o_gnt_id,
    output logic                                  o_busy,
    output logic                                  o_err,
    output logic                                  o_dbg_state
);

    // Handshake rule on every port: the receiver raises ack only while the
    // sender's rdy is high, and a transfer happens in each cycle ack is high.

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                     state, state_nxt;
    logic [GW-1:0]              rr_ptr, rr_nxt;
    logic [GW-1:0]              gnt_id, gnt_nxt;
    logic [ICFG_BW-1:0]         beat_cnt, cnt_nxt, cnt_after;
    logic [VDIM-1:0][WBW-1:0]   bofs_q, aofs_q;
    logic [ICFG_BW-1:0]         beg_q, end_q;
    logic                       err_q, err_set, load;
    logic                       win_found, mofs_beat;
    logic [GW-1:0]              win_id;
    int                         idx;

    function automatic logic [GW-1:0] next_id(input logic [GW-1:0] id);
        return (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
    endfunction

    // First ready requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_found && i_req_rdy[idx]) begin
                win_found = 1'b1;
                win_id    = GW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr_ptr;
        gnt_nxt     = gnt_id;
        cnt_nxt     = beat_cnt;
        cnt_after   = beat_cnt;
        load        = 1'b0;
        err_set     = 1'b0;
        mofs_beat   = 1'b0;
        i_req_ack   = '0;
        o_abofs_rdy = 1'b0;
        o_mofs_rdy  = '0;
        i_mofs_ack  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A beat offered with no burst in flight has nowhere to go.
                if (i_mofs_rdy) err_set = 1'b1;
                if (win_found) begin
                    i_req_ack[win_id] = 1'b1;
                    if (i_req_beg[win_id] < i_req_end[win_id]) begin
                        load      = 1'b1;
                        gnt_nxt   = win_id;
                        cnt_nxt   = i_req_end[win_id] - i_req_beg[win_id];
                        state_nxt = ST_ISSUE;
                    end else begin
                        rr_nxt = next_id(win_id);
                    end
                end
            end
            ST_ISSUE: begin
                o_abofs_rdy        = 1'b1;
                o_mofs_rdy[gnt_id] = i_mofs_rdy;
                mofs_beat          = i_mofs_rdy & o_mofs_ack[gnt_id];
                i_mofs_ack         = mofs_beat;
                if (mofs_beat && beat_cnt != '0) cnt_after = beat_cnt - 1'b1;
                cnt_nxt = cnt_after;
                if (o_abofs_ack) begin
                    // Closing the request with beats still owed is a protocol error.
                    if (cnt_after != '0) err_set = 1'b1;
                    state_nxt = ST_IDLE;
                    rr_nxt    = next_id(gnt_id);
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (i_rst) begin
            i_req_ack   = '0;
            o_abofs_rdy = 1'b0;
            o_mofs_rdy  = '0;
            i_mofs_ack  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            beat_cnt <= '0;
            bofs_q   <= '0;
            aofs_q   <= '0;
            beg_q    <= '0;
            end_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            gnt_id   <= gnt_nxt;
            beat_cnt <= cnt_nxt;
            if (err_set) err_q <= 1'b1;
            if (load) begin
                bofs_q <= i_req_bofs[win_id];
                aofs_q <= i_req_aofs[win_id];
                beg_q  <= i_req_beg[win_id];
                end_q  <= i_req_end[win_id];
            end
        end
    end

    assign o_bofs      = bofs_q;
    assign o_aofs      = aofs_q;
    assign o_beg       = beg_q;
    assign o_end       = end_q;
    assign o_mofs      = i_mofs;
    assign o_gnt_id    = gnt_id;
    assign o_busy      = (state == ST_ISSUE);
    assign o_err       = err_q;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_chunk_head_arb.sv
// Bench for chunk_head_arb: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_chunk_head_arb;

  localparam int NREQ = 2;
  localparam int WBW = 8;
  localparam int VDIM = 2;
  localparam int ICFG_BW = 4;
  localparam int GW = 1;
  localparam int PW = VDIM * WBW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0] req_rdy, req_ack;
  logic [NREQ-1:0][VDIM-1:0][WBW-1:0] req_bofs, req_aofs;
  logic [NREQ-1:0][ICFG_BW-1:0] req_beg, req_end;
  logic abofs_rdy, abofs_ack;
  logic [VDIM-1:0][WBW-1:0] out_bofs, out_aofs, mofs_in, mofs_out;
  logic [ICFG_BW-1:0] out_beg, out_end;
  logic mofs_rdy_in, mofs_ack_out;
  logic [NREQ-1:0] mofs_rdy_out, mofs_ack_in;
  logic [GW-1:0] gnt_id;
  logic busy, err, dbg_state;

  chunk_head_arb #(.NREQ(NREQ), .WBW(WBW), .VDIM(VDIM), .ICFG_BW(ICFG_BW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_rdy(req_rdy), .i_req_ack(req_ack),
    .i_req_bofs(req_bofs), .i_req_aofs(req_aofs),
    .i_req_beg(req_beg), .i_req_end(req_end),
    .o_abofs_rdy(abofs_rdy), .o_abofs_ack(abofs_ack),
    .o_bofs(out_bofs), .o_aofs(out_aofs), .o_beg(out_beg), .o_end(out_end),
    .i_mofs_rdy(mofs_rdy_in), .i_mofs_ack(mofs_ack_out), .i_mofs(mofs_in),
    .o_mofs_rdy(mofs_rdy_out), .o_mofs_ack(mofs_ack_in), .o_mofs(mofs_out),
    .o_gnt_id(gnt_id), .o_busy(busy), .o_err(err), .o_dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  bit m_busy, m_err;
  int m_gnt, m_left, m_ptr;
  logic [PW-1:0] m_bofs, m_aofs;
  logic [ICFG_BW-1:0] m_beg, m_end;
  bit prev_busy_obs;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] obs_gnt[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_gnt = 0; m_left = 0; m_ptr = 0;
    m_bofs = '0; m_aofs = '0; m_beg = '0; m_end = '0;
    prev_busy_obs = 0;
  endtask

  function automatic int find_winner();
    for (int k = 0; k < NREQ; k++)
      if (req_rdy[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req_rdy = '0; req_bofs = '0; req_aofs = '0; req_beg = '0; req_end = '0;
    abofs_ack = 0; mofs_rdy_in = 0; mofs_ack_in = '0; mofs_in = '0;
  endtask

  task automatic set_req(input int i, input int b, input int e);
    req_rdy[i] = 1'b1;
    req_beg[i] = ICFG_BW'(b);
    req_end[i] = ICFG_BW'(e);
    req_bofs[i] = PW'($urandom);
    req_aofs[i] = PW'($urandom);
  endtask

  task automatic refill(input int pct, input bit fixed);
    for (int i = 0; i < NREQ; i++)
      if (!req_rdy[i] && $urandom_range(0, 99) < pct) begin
        if (fixed) set_req(i, 0, 1);
        else set_req(i, $urandom_range(0, 7), $urandom_range(0, 9));
      end
  endtask

  // Chunk-head side: offer beats while owed, ack the request once all are through.
  task automatic drive_ch(input int stall_pct, input int hold_pct);
    int beat;
    mofs_in = PW'($urandom);
    mofs_rdy_in = m_busy && m_left > 0 && ($urandom_range(0, 99) >= 15);
    mofs_ack_in = '0;
    if (m_busy) mofs_ack_in[m_gnt] = mofs_rdy_in && ($urandom_range(0, 99) >= stall_pct);
    beat = (m_busy && mofs_ack_in[m_gnt]) ? 1 : 0;
    abofs_ack = m_busy && (m_left - beat == 0) && ($urandom_range(0, 99) >= hold_pct);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    int w;
    logic [NREQ-1:0] e_ack, e_mrdy;
    logic e_mack;
    @(negedge clk);
    w = find_winner();
    e_ack = '0;
    if (!m_busy && w >= 0) e_ack[w] = 1'b1;
    e_mrdy = '0;
    e_mack = 1'b0;
    if (m_busy && mofs_rdy_in) begin
      e_mrdy[m_gnt] = 1'b1;
      e_mack = mofs_ack_in[m_gnt];
    end
    chk("req_ack", 64'(req_ack), 64'(e_ack));
    chk("abofs_rdy", 64'(abofs_rdy), 64'(m_busy));
    chk("mofs_rdy", 64'(mofs_rdy_out), 64'(e_mrdy));
    chk("mofs_ack", 64'(mofs_ack_out), 64'(e_mack));
    chk("gnt_id", 64'(gnt_id), 64'(m_gnt));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("err", 64'(err), 64'(m_err));
    chk("bofs", 64'(out_bofs), 64'(m_bofs));
    chk("aofs", 64'(out_aofs), 64'(m_aofs));
    chk("beg", 64'(out_beg), 64'(m_beg));
    chk("end", 64'(out_end), 64'(m_end));
    chk("mofs_pass", 64'(mofs_out), 64'(mofs_in));
    if (busy === 1'b1 && !prev_busy_obs) obs_gnt.push_back(gnt_id);
    prev_busy_obs = (busy === 1'b1);
    if (!m_busy) begin
      if (mofs_rdy_in) m_err = 1;
      if (w >= 0) begin
        if (req_beg[w] < req_end[w]) begin
          m_busy = 1; m_gnt = w;
          m_left = int'(req_end[w]) - int'(req_beg[w]);
          m_bofs = req_bofs[w]; m_aofs = req_aofs[w];
          m_beg = req_beg[w]; m_end = req_end[w];
        end else begin
          m_ptr = (w + 1) % NREQ;
        end
      end
    end else begin
      if (e_mack && m_left > 0) m_left--;
      if (abofs_ack) begin
        if (m_left != 0) m_err = 1;
        m_busy = 0; m_left = 0;
        m_ptr = (m_gnt + 1) % NREQ;
      end
      w = -1;
    end
    @(posedge clk);
    #1;
    if (w >= 0) req_rdy[w] = 1'b0;
  endtask

  task automatic run(input int n, input int refill_pct, input bit fixed, input int stall, input int hold);
    for (int c = 0; c < n; c++) begin
      refill(refill_pct, fixed);
      drive_ch(stall, hold);
      step();
    end
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      drive_ch(0, 0);
      step();
      done = !m_busy && (req_rdy == '0);
    end
    chk("drain_timeout", 64'(done), 64'd1);
    drive_ch(0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    req_rdy = 2'b11; req_beg = '0; req_end = {4'd3, 4'd3};
    mofs_rdy_in = 1'b1; mofs_ack_in = 2'b11; abofs_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    chk("rst_abofs_rdy", 64'(abofs_rdy), 64'd0);
    chk("rst_mofs_rdy", 64'(mofs_rdy_out), 64'd0);
    chk("rst_mofs_ack", 64'(mofs_ack_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt_id), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_bofs", 64'(out_bofs), 64'd0);
    chk("rst_beg", 64'(out_beg), 64'd0);
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    clear_inputs();
    do_reset();

    // Single request, 3 beats, request ack with the last beat.
    set_req(0, 1, 4);
    step();
    run(6, 0, 0, 0, 0);
    drain(20);
    chk("r026_err", 64'(err), 64'd0);

    // Both requesters continuously ready: grants alternate starting at 0.
    do_reset();
    obs_gnt.delete();
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    run(12, 100, 1, 0, 0);
    drain(20);
    chk("r027_cnt", 64'(obs_gnt.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < obs_gnt.size(); i++)
      chk("r027_gnt", 64'(obs_gnt[i]), 64'(exp_q[i]));

    // Empty range on req1 is consumed and moves the pointer back to 0.
    do_reset();
    set_req(0, 0, 1);
    step();
    drain(10);
    set_req(1, 2, 2);
    step();
    step();
    chk("r028_ptr", 64'(m_ptr), 64'd0);
    obs_gnt.delete();
    set_req(0, 1, 2);
    set_req(1, 1, 2);
    step();
    step();
    chk("r028_next", 64'(obs_gnt.size() > 0 ? obs_gnt[0] : 1'bx), 64'd0);
    drain(20);

    // Return-side stall of 4 cycles in the middle of a 3-beat burst.
    set_req(0, 0, 3);
    step();
    mofs_rdy_in = 1; mofs_ack_in = 2'b01; abofs_ack = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      mofs_rdy_in = 1; mofs_ack_in = 2'b00; abofs_ack = 0;
      step();
    end
    mofs_rdy_in = 1; mofs_ack_in = 2'b01; abofs_ack = 0;
    step();
    mofs_rdy_in = 1; mofs_ack_in = 2'b01; abofs_ack = 1;
    step();
    clear_inputs();
    step();
    chk("r029_err", 64'(err), 64'd0);

    // Request closed after 1 of 2 beats, then a beat offered while idle.
    set_req(0, 0, 2);
    step();
    mofs_rdy_in = 1; mofs_ack_in = 2'b01; abofs_ack = 0;
    step();
    mofs_rdy_in = 0; mofs_ack_in = 2'b00; abofs_ack = 1;
    step();
    abofs_ack = 0;
    for (int i = 0; i < 3; i++) step();
    chk("r030_sticky", 64'(err), 64'd1);
    do_reset();
    mofs_rdy_in = 1; mofs_ack_in = 2'b01;
    step();
    clear_inputs();
    step();
    chk("r030_idle_beat", 64'(err), 64'd1);

    // Reset in the middle of a burst aborts it asynchronously.
    do_reset();
    set_req(0, 0, 3);
    step();
    mofs_rdy_in = 1; mofs_ack_in = 2'b01; abofs_ack = 0;
    step();
    set_req(1, 0, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("r031_abofs_rdy", 64'(abofs_rdy), 64'd0);
    chk("r031_busy", 64'(busy), 64'd0);
    chk("r031_mofs_rdy", 64'(mofs_rdy_out), 64'd0);
    chk("r031_mofs_ack", 64'(mofs_ack_out), 64'd0);
    chk("r031_req_ack", 64'(req_ack), 64'd0);
    chk("r031_gnt", 64'(gnt_id), 64'd0);
    chk("r031_bofs", 64'(out_bofs), 64'd0);
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    set_req(0, 2, 4);
    step();
    drain(20);
    chk("r031_err", 64'(err), 64'd0);

    // Randomized traffic with stalls, held request acks and empty ranges.
    do_reset();
    run(400, 40, 0, 30, 30);
    drain(60);
    chk("rand_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
